// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
package dm_arb_pkg;

    // Arbiter FSM states: idle, or serving one burst of requester A or B
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_A = 2'd1,
        SERVE_B = 2'd2
    } state_e;

    localparam int MEM_WORDS = 1024;
    localparam int LEN_W     = 2;
    localparam int WORD_W    = $clog2(MEM_WORDS);

    // Word index wraps inside the 4 KB window
    localparam logic [WORD_W-1:0] WRAP_MASK = WORD_W'(MEM_WORDS - 1);

    // Requester encoding used by the round-robin pointer and chooser
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    function automatic logic [WORD_W-1:0] next_word(input logic [WORD_W-1:0] w);
        return (w + 1'b1) & WRAP_MASK;
    endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Request/response bus of both requesters plus the memory-side port.
interface dm_arbiter_if
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              a_req,    b_req;
    logic              a_we,     b_we;
    logic [ADDR_W-1:0] a_addr,   b_addr;
    logic [LEN_W-1:0]  a_len,    b_len;
    logic [DATA_W-1:0] a_wdata,  b_wdata;
    logic              a_gnt,    b_gnt;
    logic              a_beat,   b_beat;
    logic              a_rvalid, b_rvalid;
    logic [DATA_W-1:0] a_rdata,  b_rdata;
    logic              a_done,   b_done;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  a_req, b_req, a_we, b_we, a_addr, b_addr, a_len, b_len,
               a_wdata, b_wdata, mem_rdata,
        output a_gnt, b_gnt, a_beat, b_beat, a_rvalid, b_rvalid,
               a_rdata, b_rdata, a_done, b_done, mem_we, mem_addr, mem_wdata
    );

    // Requester / memory side
    modport master (
        output a_req, b_req, a_we, b_we, a_addr, b_addr, a_len, b_len,
               a_wdata, b_wdata, mem_rdata,
        input  a_gnt, b_gnt, a_beat, b_beat, a_rvalid, b_rvalid,
               a_rdata, b_rdata, a_done, b_done, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dm_arbiter_rr_pick2.sv
// Two-way round-robin chooser: on a tie the requester not served last wins.
module rr_pick2
    import dm_arb_pkg::*;
(
    input  logic [1:0] req,   // bit 0 = A, bit 1 = B
    input  logic       last,  // requester served most recently
    output logic       sel    // chosen requester (valid when any req)
);
    // Tie goes to the other requester; otherwise the lone requester wins
    always_comb begin
        sel = SEL_A;
        if (req == 2'b11) begin
            sel = ~last;
        end else if (req[1]) begin
            sel = SEL_B;
        end
    end
endmodule

// File: rtl/dm_arbiter.sv
// Burst arbiter giving requesters A and B round-robin access to one
// single-port data memory; each serve cycle is one beat, bursts chain
// back to back without idle cycles.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    dm_arbiter_if.slave bus
);
    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:12]  base_hi_q, base_hi_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic                last_q, last_d;
    logic                a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
    logic                a_done_q, a_done_d, b_done_q, b_done_d;
    logic                a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
    logic [DATA_W-1:0]   a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

    logic [1:0] req;
    logic       serving, cur_sel, last_beat, pick_sel, beat_en, read_beat;

    assign req       = {bus.b_req, bus.a_req};
    assign serving   = (state_q != IDLE);
    assign cur_sel   = (state_q == SERVE_B);
    assign last_beat = serving && (cnt_q == len_q);
    assign read_beat = serving && !we_q;
    // A beat is suppressed while reset is held so an aborted burst never writes
    assign beat_en   = serving && reset;

    rr_pick2 u_pick (
        .req  (req),
        .last (last_q),
        .sel  (pick_sel)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and burst bookkeeping: advance beats, grant at burst boundaries
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        base_hi_d  = base_hi_q;
        word_d     = word_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        a_gnt_d    = 1'b0;
        b_gnt_d    = 1'b0;
        a_done_d   = last_beat && (cur_sel == SEL_A);
        b_done_d   = last_beat && (cur_sel == SEL_B);
        a_rvalid_d = read_beat && (cur_sel == SEL_A);
        b_rvalid_d = read_beat && (cur_sel == SEL_B);
        a_rdata_d  = a_rvalid_d ? bus.mem_rdata : a_rdata_q;
        b_rdata_d  = b_rvalid_d ? bus.mem_rdata : b_rdata_q;

        if (serving && !last_beat) begin
            cnt_d  = cnt_q + LEN_W'(1);
            word_d = next_word(word_q);
        end

        // last_q equals the current requester while serving, so the chooser
        // prefers the other side at a burst end and falls back to the same one
        if (state_q == IDLE || last_beat) begin
            if (|req) begin
                state_d   = (pick_sel == SEL_B) ? SERVE_B : SERVE_A;
                last_d    = pick_sel;
                we_d      = (pick_sel == SEL_B) ? bus.b_we : bus.a_we;
                len_d     = (pick_sel == SEL_B) ? bus.b_len : bus.a_len;
                base_hi_d = (pick_sel == SEL_B) ? bus.b_addr[ADDR_W-1:12]
                                                : bus.a_addr[ADDR_W-1:12];
                word_d    = (pick_sel == SEL_B) ? bus.b_addr[WORD_W+1:2]
                                                : bus.a_addr[WORD_W+1:2];
                cnt_d     = '0;
                a_gnt_d   = (pick_sel == SEL_A);
                b_gnt_d   = (pick_sel == SEL_B);
            end else begin
                state_d = IDLE;
            end
        end
    end

    // Burst registers and registered outputs; pointer resets so A wins first tie
    always_ff @(posedge clk) begin
        if (!reset) begin
            we_q       <= 1'b0;
            base_hi_q  <= '0;
            word_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            last_q     <= SEL_B;
            a_gnt_q    <= 1'b0;
            b_gnt_q    <= 1'b0;
            a_done_q   <= 1'b0;
            b_done_q   <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            we_q       <= we_d;
            base_hi_q  <= base_hi_d;
            word_q     <= word_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            a_gnt_q    <= a_gnt_d;
            b_gnt_q    <= b_gnt_d;
            a_done_q   <= a_done_d;
            b_done_q   <= b_done_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    // Outputs: memory port and beat strobes decoded from state and registers
    always_comb begin
        bus.a_beat    = beat_en && (cur_sel == SEL_A);
        bus.b_beat    = beat_en && (cur_sel == SEL_B);
        bus.mem_we    = beat_en && we_q;
        bus.mem_addr  = beat_en ? {base_hi_q, word_q, 2'b00} : '0;
        bus.mem_wdata = (beat_en && we_q) ? ((cur_sel == SEL_B) ? bus.b_wdata : bus.a_wdata)
                                          : '0;
        bus.a_gnt     = a_gnt_q;
        bus.b_gnt     = b_gnt_q;
        bus.a_done    = a_done_q;
        bus.b_done    = b_done_q;
        bus.a_rvalid  = a_rvalid_q;
        bus.b_rvalid  = b_rvalid_q;
        bus.a_rdata   = a_rdata_q;
        bus.b_rdata   = b_rdata_q;
    end
endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: every expected grant, beat, read return
// and done is queued with its cycle when stimulus is applied and matched
// against what the arbiter produces.
module tb_dm_arbiter;
    import dm_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int K_GNT  = 0;
    localparam int K_BEAT = 1;
    localparam int K_RVAL = 2;
    localparam int K_DONE = 3;

    typedef struct {
        int          cyc;
        int          kind;
        int          who;
        logic [31:0] addr;
        logic        we;
        logic [31:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic mem_init = 1'b0;
    logic mon_en = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   st;
    ev_t  sb[$];
    logic [31:0] tbmem [MEM_WORDS];

    always #5 clk = ~clk;

    dm_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dm_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [31:0] init_val(input logic [9:0] w);
        if (w == 10'd1023) return 32'h0000_00AA;
        if (w == 10'd0)    return 32'h0000_00BB;
        return 32'h5500_0000 | {22'h0, w};
    endfunction

    function automatic logic [31:0] wpattern(input int who, input int c);
        logic [31:0] cc;
        cc = c;
        return (who != 0 ? 32'hB000_0000 : 32'hA000_0000) | {16'h0, cc[15:0]};
    endfunction

    function automatic string kname(input int k);
        case (k)
            K_GNT:   return "gnt";
            K_BEAT:  return "beat";
            K_RVAL:  return "rvalid";
            default: return "done";
        endcase
    endfunction

    // Memory model: combinational read, write on the clock edge
    assign bus.mem_rdata = tbmem[bus.mem_addr[11:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_init) begin
            for (int i = 0; i < MEM_WORDS; i++) tbmem[i] <= init_val(10'(i));
        end else if (bus.mem_we === 1'b1) begin
            tbmem[bus.mem_addr[11:2]] <= bus.mem_wdata;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, got, want, cyc);
    endtask

    task automatic push_ev(input int c, input int k, input int who,
                           input logic [31:0] addr, input logic we, input logic [31:0] data);
        ev_t e;
        e.cyc = c; e.kind = k; e.who = who; e.addr = addr; e.we = we; e.data = data;
        sb.push_back(e);
    endtask

    task automatic expect_burst(input int who, input logic we, input logic [31:0] addr,
                                input int len, input int start);
        logic [9:0]  w;
        logic [31:0] ma;
        push_ev(start, K_GNT, who, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i <= len; i++) begin
            w  = addr[11:2] + 10'(i);
            ma = {addr[31:12], w, 2'b00};
            push_ev(start + i, K_BEAT, who, ma, we, we ? wpattern(who, start + i) : 32'h0);
            if (!we) push_ev(start + i + 1, K_RVAL, who, 32'h0, 1'b0, init_val(w));
        end
        push_ev(start + len + 1, K_DONE, who, 32'h0, 1'b0, 32'h0);
        $display("burst %s we=%0d addr=0x%08h len=%0d start=%0d",
                 who != 0 ? "B" : "A", we, addr, len, start);
    endtask

    task automatic observe(input int k, input int who, input logic [31:0] addr,
                           input logic we, input logic [31:0] data);
        int    j;
        string tag;
        j = -1;
        foreach (sb[i]) begin
            if (j < 0 && sb[i].cyc == cyc && sb[i].kind == k && sb[i].who == who) j = i;
        end
        tag = $sformatf("%s_%s@%0d", who != 0 ? "b" : "a", kname(k), cyc);
        check_eq({tag, "_expected"}, 64'(j >= 0), 64'd1);
        if (j >= 0) begin
            if (k == K_BEAT) begin
                check_eq({tag, "_addr"}, 64'(addr), 64'(sb[j].addr));
                check_eq({tag, "_we"}, 64'(we), 64'(sb[j].we));
                check_eq({tag, "_wdata"}, 64'(data), 64'(sb[j].data));
            end else if (k == K_RVAL) begin
                check_eq({tag, "_rdata"}, 64'(data), 64'(sb[j].data));
            end
            sb.delete(j);
        end
        $display("cyc %0d %s addr=0x%08h we=%0d data=0x%08h", cyc, tag, addr, we, data);
    endtask

    // Monitor: sample all outputs on the falling edge
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.a_gnt)    observe(K_GNT, 0, 32'h0, 1'b0, 32'h0);
            if (bus.b_gnt)    observe(K_GNT, 1, 32'h0, 1'b0, 32'h0);
            if (bus.a_beat)   observe(K_BEAT, 0, bus.mem_addr, bus.mem_we, bus.mem_wdata);
            if (bus.b_beat)   observe(K_BEAT, 1, bus.mem_addr, bus.mem_we, bus.mem_wdata);
            if (bus.a_rvalid) observe(K_RVAL, 0, 32'h0, 1'b0, bus.a_rdata);
            if (bus.b_rvalid) observe(K_RVAL, 1, 32'h0, 1'b0, bus.b_rdata);
            if (bus.a_done)   observe(K_DONE, 0, 32'h0, 1'b0, 32'h0);
            if (bus.b_done)   observe(K_DONE, 1, 32'h0, 1'b0, 32'h0);
            if (!(bus.a_beat === 1'b1) && !(bus.b_beat === 1'b1))
                check_eq("idle_mem_we_wdata", {31'h0, bus.mem_we, bus.mem_wdata}, 64'h0);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        bus.a_wdata = wpattern(0, cyc);
        bus.b_wdata = wpattern(1, cyc);
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_gnt"},    {62'h0, bus.a_gnt, bus.b_gnt}, 64'h0);
        check_eq({tag, "_beat"},   {62'h0, bus.a_beat, bus.b_beat}, 64'h0);
        check_eq({tag, "_rvalid"}, {62'h0, bus.a_rvalid, bus.b_rvalid}, 64'h0);
        check_eq({tag, "_done"},   {62'h0, bus.a_done, bus.b_done}, 64'h0);
        check_eq({tag, "_rdata"},  {bus.a_rdata, bus.b_rdata}, 64'h0);
        check_eq({tag, "_mem"},    {bus.mem_we, bus.mem_addr, bus.mem_wdata[30:0]}, 64'h0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        next_cycle();
        next_cycle();
        check_quiet("reset");
        reset = 1'b1;
    endtask

    task automatic settle(input int n);
        repeat (n) next_cycle();
        check_eq("scoreboard_drained", 64'(sb.size()), 64'h0);
        sb.delete();
    endtask

    initial begin
        bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_len = '0; bus.a_wdata = '0;
        bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_len = '0; bus.b_wdata = '0;
        mem_init = 1'b1;
        do_reset();
        mem_init = 1'b0;
        mon_en = 1'b1;

        // A alone: 4-beat write at 0x10
        bus.a_req = 1; bus.a_we = 1; bus.a_addr = 32'h10; bus.a_len = 2'd3;
        st = cyc + 1;
        expect_burst(0, 1'b1, 32'h10, 3, st);
        next_cycle();
        bus.a_req = 0;
        settle(8);

        // Tie from IDLE after reset: A then B on the very next cycle
        do_reset();
        bus.a_req = 1; bus.a_we = 0; bus.a_addr = 32'h20; bus.a_len = 2'd0;
        bus.b_req = 1; bus.b_we = 1; bus.b_addr = 32'h40; bus.b_len = 2'd0;
        st = cyc + 1;
        expect_burst(0, 1'b0, 32'h20, 0, st);
        expect_burst(1, 1'b1, 32'h40, 0, st + 1);
        next_cycle();
        bus.a_req = 0;
        next_cycle();
        bus.b_req = 0;
        settle(6);

        // B read across the window wrap: 0xFFC then 0x000
        bus.b_req = 1; bus.b_we = 0; bus.b_addr = 32'hFFC; bus.b_len = 2'd1;
        st = cyc + 1;
        expect_burst(1, 1'b0, 32'hFFC, 1, st);
        next_cycle();
        bus.b_req = 0;
        settle(6);

        // Both held continuously: A,B,A,B
        do_reset();
        bus.a_req = 1; bus.a_we = 1; bus.a_addr = 32'h200; bus.a_len = 2'd1;
        bus.b_req = 1; bus.b_we = 0; bus.b_addr = 32'h300; bus.b_len = 2'd1;
        st = cyc + 1;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) expect_burst(0, 1'b1, 32'h200, 1, st + 2 * i);
            else            expect_burst(1, 1'b0, 32'h300, 1, st + 2 * i);
        end
        repeat (7) next_cycle();
        bus.a_req = 0; bus.b_req = 0;
        settle(6);

        // A alone held: same requester chains; addr[1:0] ignored (0x413 -> 0x410)
        bus.a_req = 1; bus.a_we = 0; bus.a_addr = 32'h413; bus.a_len = 2'd0;
        st = cyc + 1;
        for (int i = 0; i < 3; i++) expect_burst(0, 1'b0, 32'h413, 0, st + i);
        repeat (3) next_cycle();
        bus.a_req = 0;
        settle(6);

        // Reset on the 2nd beat of a 4-beat write aborts it
        bus.a_req = 1; bus.a_we = 1; bus.a_addr = 32'h100; bus.a_len = 2'd3;
        st = cyc + 1;
        push_ev(st, K_GNT, 0, 32'h0, 1'b0, 32'h0);
        push_ev(st, K_BEAT, 0, 32'h100, 1'b1, wpattern(0, st));
        $display("burst A we=1 addr=0x00000100 len=3 start=%0d (reset on beat 2)", st);
        next_cycle();
        bus.a_req = 0;
        next_cycle();
        reset = 1'b0;
        next_cycle();
        check_quiet("midburst_reset");
        next_cycle();
        reset = 1'b1;
        check_eq("abort_beat1_written", 64'(tbmem[10'h040]), 64'(wpattern(0, st)));
        check_eq("abort_beat2_not_written", 64'(tbmem[10'h041]), 64'(init_val(10'h041)));
        settle(6);

        // Tie right after reset: A wins again; A write wraps inside its 4 KB window
        bus.a_req = 1; bus.a_we = 1; bus.a_addr = 32'h0001_2FF8; bus.a_len = 2'd3;
        bus.b_req = 1; bus.b_we = 0; bus.b_addr = 32'h808;       bus.b_len = 2'd0;
        st = cyc + 1;
        expect_burst(0, 1'b1, 32'h0001_2FF8, 3, st);
        expect_burst(1, 1'b0, 32'h808, 0, st + 4);
        next_cycle();
        bus.a_req = 0;
        repeat (4) next_cycle();
        bus.b_req = 0;
        settle(6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 The module SHALL have parameter DATA_W, default 32, word width.
REQ-003 The module SHALL have port clk, input, 1, rising-edge clock.
REQ-004 The module SHALL have port reset, input, 1, synchronous, active-low reset.
REQ-005 The module SHALL have ports a_req/b_req, input, 1 each, access request from the pipeline MEM stage (A) and the DMA/debug port (B).
REQ-006 The module SHALL have ports a_we/b_we, input, 1 each, write (1) or read (0); sampled at grant.
REQ-007 The module SHALL have ports a_addr/b_addr, input, ADDR_W each, burst base byte address; sampled at grant.
REQ-008 The module SHALL have ports a_len/b_len, input, 2 each, burst length minus 1 (1-4 words); sampled at grant.
REQ-009 The module SHALL have ports a_wdata/b_wdata, input, DATA_W each, write data for the current beat; sampled on every beat.
REQ-010 The module SHALL have ports a_gnt/b_gnt, output, 1 each, one-cycle grant pulse.
REQ-011 The module SHALL have ports a_beat/b_beat, output, 1 each, beat consumed this cycle.
REQ-012 The module SHALL have ports a_rvalid/b_rvalid and a_rdata/b_rdata, output, 1 and DATA_W, registered read data.
REQ-013 The module SHALL have ports a_done/b_done, output, 1 each, one-cycle pulse after the last beat.
REQ-014 The module SHALL have ports mem_we (out, 1), mem_addr (out, ADDR_W), mem_wdata (out, DATA_W) and mem_rdata (in, DATA_W, combinational read) to the single-port 1024-word data memory.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, SERVE_A and SERVE_B.
REQ-016 In IDLE with exactly one request asserted, the FSM SHALL enter the matching SERVE state on the next edge.
REQ-017 In IDLE with both requests asserted, the FSM SHALL grant the requester not served last (round-robin); the pointer SHALL initialise so that A wins first.
REQ-018 On entry to SERVE_x, x_gnt SHALL be high for exactly the first cycle, and we/addr/len SHALL be latched at that edge.
REQ-019 Each SERVE cycle SHALL be one beat: x_beat=1, mem_addr={base[ADDR_W-1:12], word[9:0], 2'b00}, with addr[1:0] ignored.
REQ-020 The beat word index SHALL start at base[11:2] and increment by 1 per beat, wrapping 1023->0 within the 4 KB window.
REQ-021 mem_we SHALL be 1 only on beats of a latched write; mem_wdata SHALL equal x_wdata in that cycle; at all other times mem_we=0 and mem_wdata=0.
REQ-022 For a read beat, x_rvalid SHALL be 1 the following cycle, with x_rdata = the mem_rdata sampled on that beat; rvalid SHALL be 0 otherwise.
REQ-023 After beat number len, x_done SHALL pulse once; the next state SHALL be: SERVE of the other requester if its req=1, else SERVE of the same requester if its req=1, else IDLE.
REQ-024 No idle cycle SHALL be inserted between back-to-back bursts; a new grant SHALL pulse on the first beat of each burst.
REQ-025 Deassertion of req during a burst SHALL NOT shorten the burst.
REQ-026 A burst SHALL always take len+1 cycles; worst-case wait for a requester SHALL be one foreign burst (at most 4 cycles).

Reset
REQ-027 When reset=0 at a rising edge, the FSM SHALL return to IDLE and the pointer SHALL be set so that A wins the next tie.
REQ-028 When reset=0 at a rising edge, all gnt, beat, rvalid and done outputs, plus rdata, mem_we, mem_addr and mem_wdata, SHALL be 0.
REQ-029 A reset asserted mid-burst SHALL abort the burst with no further mem_we and no done pulse.

Structure
REQ-030 A package dm_arb_pkg SHALL hold the state enum, MEM_WORDS=1024, LEN_W=2 and the window-wrap mask.
REQ-031 One sub-module, rr_pick2 (2-way round-robin chooser: req[1:0], last -> sel), SHALL be instantiated.
REQ-032 All outputs SHALL be registered except mem_* and x_beat, which SHALL be decoded from the state and registers only, never from req inputs.

Verification
REQ-033 Scenario: a_req only, a_we=1, addr=0x10, len=3 -> mem_we 4 cycles at 0x10,0x14,0x18,0x1C; a_done on the following cycle.
REQ-034 Scenario: a_req and b_req asserted together from IDLE, len=0 each -> A granted first, B granted on the very next cycle, no idle gap.
REQ-035 Scenario: b read, addr=0xFFC, len=1, memory words 1023=0xAA and 0=0xBB -> mem_addr 0xFFC then 0x000; b_rdata 0xAA then 0xBB, each with b_rvalid.
REQ-036 Scenario: a_req held continuously and b_req held continuously -> grants alternate A,B,A,B.
REQ-037 Scenario: reset=0 on the 2nd beat of a 4-beat write -> only 1 beat written, no done pulse, state IDLE, all outputs 0.
REQ-038 Scenario: addr=0x13 -> mem_addr 0x10.
